// File: rtl/skeleton_pkg.sv
// skeleton_pkg: ISA constants, instruction field helpers and stage bundles
// shared by the skeleton 5-stage core and its register file.
package skeleton_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam logic [4:0]  REG_STATUS = 5'd30;
    localparam logic [4:0]  REG_LINK   = 5'd31;

    localparam int OP_MSB  = 31;
    localparam int RD_MSB  = 26;
    localparam int RS_MSB  = 21;
    localparam int RT_MSB  = 16;
    localparam int SH_MSB  = 11;
    localparam int AOP_MSB = 6;
    localparam int IMM_W   = 17;
    localparam int TGT_W   = 27;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] res;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] res;
    } mem_wb_t;

    function automatic logic [4:0] f_op(input logic [31:0] ir);
        return ir[OP_MSB -: 5];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_MSB -: 5];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[RS_MSB -: 5];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[RT_MSB -: 5];
    endfunction

    function automatic logic [4:0] f_sh(input logic [31:0] ir);
        return ir[SH_MSB -: 5];
    endfunction

    function automatic logic [4:0] f_aop(input logic [31:0] ir);
        return ir[AOP_MSB -: 5];
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] ir);
        return {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    endfunction

    function automatic logic [31:0] f_tgt(input logic [31:0] ir);
        return {{(32-TGT_W){1'b0}}, ir[TGT_W-1:0]};
    endfunction

    // Destination register, or 0 when the instruction writes nothing.
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        logic [4:0] op;
        op = f_op(ir);
        dest_of = 5'd0;
        unique case (1'b1)
            op == OP_ALU:
                dest_of = (f_aop(ir) <= ALU_SRA) ? f_rd(ir) : 5'd0;
            op == OP_ADDI, op == OP_LW: dest_of = f_rd(ir);
            op == OP_JAL:  dest_of = REG_LINK;
            op == OP_SETX: dest_of = REG_STATUS;
            default: ;
        endcase
    endfunction

    function automatic logic [4:0] src_a(input logic [31:0] ir);
        logic [4:0] op;
        op = f_op(ir);
        src_a = 5'd0;
        unique case (1'b1)
            op == OP_ALU, op == OP_ADDI, op == OP_LW,
            op == OP_SW, op == OP_BNE, op == OP_BLT: src_a = f_rs(ir);
            op == OP_BEX: src_a = REG_STATUS;
            default: ;
        endcase
    endfunction

    function automatic logic [4:0] src_b(input logic [31:0] ir);
        logic [4:0] op;
        op = f_op(ir);
        src_b = 5'd0;
        unique case (1'b1)
            op == OP_ALU: src_b = f_rt(ir);
            op == OP_SW, op == OP_BNE,
            op == OP_BLT, op == OP_JR: src_b = f_rd(ir);
            default: ;
        endcase
    endfunction

    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic [4:0] x_rd,
        input logic [4:0] m_rd
    );
        return (src != 5'd0) && (src == x_rd || src == m_rd);
    endfunction

endpackage

// File: rtl/skeleton_if.sv
// skeleton_if: register-file access bundle between the core (master)
// and the register file (slave): two read ports and one write port.
interface skeleton_if;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    modport master (
        output ra_addr, rb_addr, we, wa, wd,
        input  ra_data, rb_data
    );

    modport slave (
        input  ra_addr, rb_addr, we, wa, wd,
        output ra_data, rb_data
    );
endinterface

// File: rtl/skeleton_regfile.sv
// skeleton_regfile: 32x32 register file, r0 hard-wired to zero,
// same-cycle write-through from the write port to both read ports.
module skeleton_regfile (
    input  logic       clock,
    input  logic       reset,
    skeleton_if.slave  rf
);
    logic [31:0] register_output [0:31];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                register_output[i] <= '0;
            end
        end else if (rf.we && rf.wa != 5'd0) begin
            register_output[rf.wa] <= rf.wd;
        end
    end

    assign rf.ra_data = (rf.ra_addr == 5'd0) ? 32'd0 :
                        (rf.we && rf.wa == rf.ra_addr) ? rf.wd :
                        register_output[rf.ra_addr];

    assign rf.rb_data = (rf.rb_addr == 5'd0) ? 32'd0 :
                        (rf.we && rf.wa == rf.rb_addr) ? rf.wd :
                        register_output[rf.rb_addr];
endmodule

// File: rtl/skeleton.sv
// skeleton: 5-stage 32-bit core (F D X M W) with instruction ROM, data RAM
// and register file; RAW hazards stall in D, control transfers resolve in X.
module skeleton #(
    parameter string IMEM_INIT = "imem.mem",
    parameter int    MEM_DEPTH = 4096
) (
    input  logic clock,
    input  logic reset
);
    import skeleton_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] imem [MEM_DEPTH];
    logic [31:0] dmem [MEM_DEPTH];

    logic [31:0] pc;
    if_id_t      fd;
    id_ex_t      dx;
    ex_mem_t     xm;
    mem_wb_t     mw;

    skeleton_if rf_if ();

    skeleton_regfile my_regfile (
        .clock (clock),
        .reset (reset),
        .rf    (rf_if)
    );

    logic [4:0] d_ra, d_rb, x_rd, m_rd;
    logic       stall;

    assign d_ra  = src_a(fd.ir);
    assign d_rb  = src_b(fd.ir);
    assign x_rd  = dest_of(dx.ir);
    assign m_rd  = dest_of(xm.ir);
    assign stall = raw_hit(d_ra, x_rd, m_rd) || raw_hit(d_rb, x_rd, m_rd);

    assign rf_if.ra_addr = d_ra;
    assign rf_if.rb_addr = d_rb;

    logic [4:0]  x_op, x_aop, x_sh;
    logic [31:0] x_imm, x_pc1, x_res, x_target;
    logic        x_redirect;

    assign x_op  = f_op(dx.ir);
    assign x_aop = f_aop(dx.ir);
    assign x_sh  = f_sh(dx.ir);
    assign x_imm = f_imm(dx.ir);
    assign x_pc1 = dx.pc + 32'd1;

    always_comb begin
        x_res      = '0;
        x_target   = '0;
        x_redirect = 1'b0;
        unique case (1'b1)
            x_op == OP_ALU: begin
                case (x_aop)
                    ALU_ADD: x_res = dx.a + dx.b;
                    ALU_SUB: x_res = dx.a - dx.b;
                    ALU_AND: x_res = dx.a & dx.b;
                    ALU_OR:  x_res = dx.a | dx.b;
                    ALU_SLL: x_res = dx.a << x_sh;
                    ALU_SRA: x_res = $unsigned($signed(dx.a) >>> x_sh);
                    default: x_res = '0;
                endcase
            end
            x_op == OP_ADDI, x_op == OP_LW, x_op == OP_SW:
                x_res = dx.a + x_imm;
            x_op == OP_J: begin
                x_redirect = 1'b1;
                x_target   = f_tgt(dx.ir);
            end
            x_op == OP_JAL: begin
                x_redirect = 1'b1;
                x_target   = f_tgt(dx.ir);
                x_res      = x_pc1;
            end
            x_op == OP_JR: begin
                x_redirect = 1'b1;
                x_target   = dx.b;
            end
            x_op == OP_BNE: begin
                x_redirect = dx.b != dx.a;
                x_target   = x_pc1 + x_imm;
            end
            x_op == OP_BLT: begin
                x_redirect = $signed(dx.b) < $signed(dx.a);
                x_target   = x_pc1 + x_imm;
            end
            x_op == OP_SETX: x_res = f_tgt(dx.ir);
            x_op == OP_BEX: begin
                x_redirect = dx.a != 32'd0;
                x_target   = f_tgt(dx.ir);
            end
            default: ;
        endcase
    end

    logic [AW-1:0] m_addr;
    logic [31:0]   m_res;

    assign m_addr = xm.res[AW-1:0];
    assign m_res  = (f_op(xm.ir) == OP_LW) ? dmem[m_addr] : xm.res;

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (f_op(xm.ir) == OP_SW) begin
            dmem[m_addr] <= xm.b;
        end
    end

    assign rf_if.wa = dest_of(mw.ir);
    assign rf_if.we = rf_if.wa != 5'd0;
    assign rf_if.wd = mw.res;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
            fd <= '0;
            dx <= '0;
            xm <= '0;
            mw <= '0;
        end else begin
            xm.ir  <= dx.ir;
            xm.res <= x_res;
            xm.b   <= dx.b;
            mw.ir  <= xm.ir;
            mw.res <= m_res;
            if (x_redirect) begin
                pc <= x_target;
                fd <= '0;
                dx <= '0;
            end else if (stall) begin
                dx <= '0;
            end else begin
                pc    <= pc + 32'd1;
                fd.pc <= pc;
                fd.ir <= imem[pc[AW-1:0]];
                dx.pc <= fd.pc;
                dx.ir <= fd.ir;
                dx.a  <= rf_if.ra_data;
                dx.b  <= rf_if.rb_data;
            end
        end
    end
endmodule

// File: tb/tb_skeleton.sv
// tb_skeleton: scoreboard bench for the skeleton core; programs are placed
// in the instruction ROM and results read from the register file array.
module tb_skeleton;
    import skeleton_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    skeleton #(
        .IMEM_INIT ("imem.mem"),
        .MEM_DEPTH (4096)
    ) dut (
        .clock (clock),
        .reset (reset)
    );

    typedef struct {
        int          r;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] enc_r(int rd, int rs, int rt, int sh,
                                          logic [4:0] aop);
        return {OP_ALU, 5'(rd), 5'(rs), 5'(rt), 5'(sh), aop, 2'b00};
    endfunction

    function automatic logic [31:0] enc_i(logic [4:0] op, int rd, int rs,
                                          int imm);
        logic [31:0] t;
        t = imm;
        return {op, 5'(rd), 5'(rs), t[16:0]};
    endfunction

    function automatic logic [31:0] enc_j(logic [4:0] op, int tgt);
        logic [31:0] t;
        t = tgt;
        return {op, t[26:0]};
    endfunction

    task automatic expect_reg(int r, logic [31:0] v);
        exp_t e;
        e.r = r;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic start_program();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) dut.imem[i] = NOP;
        foreach (prog[i]) dut.imem[i] = prog[i];
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_independent();
        exp_t        e;
        logic [31:0] got;
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 1, 0, 5)); expect_reg(1, 32'd5);
        prog.push_back(enc_i(OP_ADDI, 2, 0, 7)); expect_reg(2, 32'd7);
        prog.push_back(enc_i(OP_ADDI, 0, 0, 9)); expect_reg(0, 32'd0);
        prog.push_back(NOP);
        prog.push_back(NOP);
        prog.push_back(enc_r(3, 1, 2, 0, ALU_ADD)); expect_reg(3, 32'd12);
        start_program();
        repeat (4) @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL latency_early r1: got %h, expected %h", got, 32'd0);
        end
        @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd5) begin
            miscompares++;
            $display("FAIL latency_wb r1: got %h, expected %h", got, 32'd5);
        end
        repeat (40) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL independent r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] got;
        for (int i = 0; i < 32; i++) expect_reg(i, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL reset r%0d: got %h, expected %h", e.r, got, e.v);
            end
        end
        vectors++;
        if (dut.pc !== 32'd0) begin
            miscompares++;
            $display("FAIL reset pc: got %h, expected %h", dut.pc, 32'd0);
        end
        vectors++;
        if (dut.fd.ir !== NOP) begin
            miscompares++;
            $display("FAIL reset fd_ir: got %h, expected %h", dut.fd.ir, NOP);
        end
    endtask

    task automatic load_dependent();
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 1, 0, 3));
        prog.push_back(enc_i(OP_ADDI, 1, 1, 4)); expect_reg(1, 32'd7);
        prog.push_back(enc_r(2, 1, 0, 0, ALU_SUB)); expect_reg(2, 32'd7);
        prog.push_back(enc_r(3, 1, 0, 2, ALU_SLL)); expect_reg(3, 32'd28);
    endtask

    task automatic test_dependent();
        exp_t        e;
        logic [31:0] got;
        load_dependent();
        start_program();
        repeat (7) @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd3) begin
            miscompares++;
            $display("FAIL stall_e7 r1: got %h, expected %h", got, 32'd3);
        end
        @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd7) begin
            miscompares++;
            $display("FAIL stall_e8 r1: got %h, expected %h", got, 32'd7);
        end
        repeat (2) @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[2];
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL stall_e10 r2: got %h, expected %h", got, 32'd0);
        end
        @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[2];
        if (got !== 32'd7) begin
            miscompares++;
            $display("FAIL stall_e11 r2: got %h, expected %h", got, 32'd7);
        end
        @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[3];
        if (got !== 32'd28) begin
            miscompares++;
            $display("FAIL stall_e12 r3: got %h, expected %h", got, 32'd28);
        end
        repeat (30) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL dependent r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
    endtask

    task automatic test_shift_mem();
        exp_t        e;
        logic [31:0] got;
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 1, 0, 32'h1FFFF));
        prog.push_back(enc_r(2, 1, 0, 4, ALU_SRA)); expect_reg(2, 32'hFFFF_FFFF);
        prog.push_back(enc_i(OP_ADDI, 3, 0, 32'h10)); expect_reg(3, 32'h10);
        prog.push_back(enc_i(OP_SW, 3, 3, 0));
        prog.push_back(enc_i(OP_LW, 1, 3, 0)); expect_reg(1, 32'h10);
        prog.push_back(enc_r(4, 0, 3, 0, ALU_SUB)); expect_reg(4, 32'hFFFF_FFF0);
        prog.push_back(enc_r(5, 4, 3, 0, ALU_AND)); expect_reg(5, 32'h10);
        prog.push_back(enc_r(6, 4, 3, 0, ALU_OR)); expect_reg(6, 32'hFFFF_FFF0);
        start_program();
        repeat (60) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL shift_mem r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
        vectors++;
        if (dut.dmem[16] !== 32'h10) begin
            miscompares++;
            $display("FAIL store dmem16: got %h, expected %h",
                     dut.dmem[16], 32'h10);
        end
    endtask

    task automatic test_branch();
        exp_t        e;
        logic [31:0] got;
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 1, 0, 1)); expect_reg(1, 32'd1);
        prog.push_back(enc_i(OP_BNE, 0, 1, 2));
        prog.push_back(enc_i(OP_ADDI, 2, 0, 9)); expect_reg(2, 32'd0);
        prog.push_back(enc_i(OP_ADDI, 2, 0, 9));
        prog.push_back(enc_i(OP_ADDI, 4, 0, 5)); expect_reg(4, 32'd5);
        prog.push_back(enc_i(OP_BLT, 4, 0, 1));
        prog.push_back(enc_i(OP_ADDI, 5, 0, 6)); expect_reg(5, 32'd6);
        prog.push_back(enc_i(OP_BLT, 0, 4, 1));
        prog.push_back(enc_i(OP_ADDI, 6, 0, 7)); expect_reg(6, 32'd0);
        prog.push_back(enc_i(OP_ADDI, 7, 0, 8)); expect_reg(7, 32'd8);
        prog.push_back(enc_i(OP_BNE, 1, 1, 1));
        prog.push_back(enc_i(OP_ADDI, 8, 0, 1)); expect_reg(8, 32'd1);
        prog.push_back(enc_i(OP_ADDI, 9, 0, -2)); expect_reg(9, 32'hFFFF_FFFE);
        prog.push_back(enc_i(OP_BLT, 9, 0, 1));
        prog.push_back(enc_i(OP_ADDI, 10, 0, 1)); expect_reg(10, 32'd0);
        prog.push_back(enc_i(OP_ADDI, 11, 0, 2)); expect_reg(11, 32'd2);
        start_program();
        repeat (80) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL branch r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
    endtask

    task automatic test_jump();
        exp_t        e;
        logic [31:0] got;
        prog = {};
        prog.push_back(enc_i(OP_ADDI, 1, 0, 1)); expect_reg(1, 32'd1);
        prog.push_back(NOP);
        prog.push_back(NOP);
        prog.push_back(enc_j(OP_JAL, 10)); expect_reg(31, 32'd4);
        prog.push_back(enc_i(OP_ADDI, 3, 0, 3)); expect_reg(3, 32'd3);
        prog.push_back(enc_j(OP_SETX, 0));
        prog.push_back(enc_j(OP_BEX, 20));
        prog.push_back(enc_i(OP_ADDI, 4, 0, 4)); expect_reg(4, 32'd4);
        prog.push_back(enc_j(OP_SETX, 9)); expect_reg(30, 32'd9);
        prog.push_back(enc_j(OP_BEX, 14));
        prog.push_back(enc_i(OP_ADDI, 2, 0, 2)); expect_reg(2, 32'd2);
        prog.push_back(enc_i(OP_JR, 31, 0, 0));
        prog.push_back(enc_i(OP_ADDI, 5, 0, 5)); expect_reg(5, 32'd0);
        prog.push_back(enc_i(OP_ADDI, 5, 0, 5));
        prog.push_back(enc_i(OP_ADDI, 6, 0, 6)); expect_reg(6, 32'd6);
        prog.push_back(enc_j(OP_J, 17));
        prog.push_back(enc_i(OP_ADDI, 7, 0, 7)); expect_reg(7, 32'd0);
        prog.push_back(enc_i(OP_ADDI, 8, 0, 8)); expect_reg(8, 32'd8);
        start_program();
        repeat (100) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL jump r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t        e;
        logic [31:0] got;
        load_dependent();
        start_program();
        repeat (6) @(posedge clock);
        #1 reset = 1'b1;
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL midrun_clear r1: got %h, expected %h", got, 32'd0);
        end
        vectors++;
        if (dut.pc !== 32'd0) begin
            miscompares++;
            $display("FAIL midrun_pc: got %h, expected %h", dut.pc, 32'd0);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1 vectors++;
        got = dut.my_regfile.register_output[1];
        if (got !== 32'd3) begin
            miscompares++;
            $display("FAIL midrun_restart r1: got %h, expected %h", got, 32'd3);
        end
        repeat (40) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = dut.my_regfile.register_output[e.r];
            vectors++;
            if (got !== e.v) begin
                miscompares++;
                $display("FAIL midrun r%0d: got %h, expected %h",
                         e.r, got, e.v);
            end
        end
    endtask

    initial begin
        test_independent();
        test_reset();
        test_dependent();
        test_shift_mem();
        test_branch();
        test_jump();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
